multicycle_controller: RTL and testbench

Finite-state controller that sequences the LEGv8 datapath (pc, instruction memory, register bank, ALU, data memory) over several cycles per instruction instead of one. It replaces the combinational ControlUnit plus the branch AND gate. It decodes the 11-bit opcode once per instruction and issues per-state enables. Data memory accesses use a ready handshake so slow memories can stall. It also retires a running instruction count and halts on illegal opcodes or memory timeouts.

---
 rtl/multicycle_controller_if.sv | 56 +++++
 rtl/multicycle_controller.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// ----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the multicycle controller and the LEGv8 datapath.
//   master : controller side. It takes opcode/zero/mem_ready and drives the
//            enables, the selects, the status flags and the retire count.
//   slave  : datapath side. Directions are the mirror image of master.
// Signals:
//   opcode      instruction[31:21] from the instruction register
//   zero        ALU zero flag
//   mem_ready   data memory access complete
//   ir_write    load instruction register
//   pc_write    load PC this edge
//   pc_src      0 = PC+4, 1 = branch target
//   reg_to_loc  register port-2 address select (1 = Rt)
//   reg_write   register bank write enable
//   alu_src     0 = register, 1 = sign-extended immediate
//   alu_op      00 add, 01 pass-B, 10 R-type funct
//   mem_req     data memory request
//   mem_we      1 = store (valid with mem_req)
//   mem_to_reg  write-back source (1 = data memory)
//   halted      sticky stop flag
//   error       sticky, halt caused by a memory timeout
//   instr_count retired instruction count
// ----------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_to_loc;
  logic             reg_write;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             mem_req;
  logic             mem_we;
  logic             mem_to_reg;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output ir_write, pc_write, pc_src, reg_to_loc, reg_write, alu_src,
           alu_op, mem_req, mem_we, mem_to_reg, halted, error, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_write, pc_write, pc_src, reg_to_loc, reg_write, alu_src,
           alu_op, mem_req, mem_we, mem_to_reg, halted, error, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// FSM that sequences the LEGv8 datapath over several cycles per instruction:
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. Data memory accesses
// wait on mem_ready, with a bounded wait that halts with error=1. Illegal
// opcodes halt with error=0. Every pc_write retires one instruction.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; forces every output to 0 while high
//   bus    multicycle_controller_if.master (see interface file)
// Parameters:
//   TIMEOUT  maximum MEM cycles waiting for mem_ready (1..255)
//   CNT_W    width of instr_count
// ----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // C_NONE doubles as "illegal opcode" out of the decoder.
  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_R    = 3'd1;
  localparam logic [2:0] C_LD   = 3'd2;
  localparam logic [2:0] C_ST   = 3'd3;
  localparam logic [2:0] C_CBZ  = 3'd4;
  localparam logic [2:0] C_B    = 3'd5;

  // Wait-counter value seen during the TIMEOUT-th MEM cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  function automatic logic [2:0] decode_class(input logic [10:0] op);
    logic [2:0] cls;
    cls = C_NONE;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls = C_R;
      11'b11111000010: cls = C_LD;
      11'b11111000000: cls = C_ST;
      11'b10110100???: cls = C_CBZ;
      11'b000101?????: cls = C_B;
      default:         cls = C_NONE;
    endcase
    return cls;
  endfunction

  logic [2:0]       r_state;
  logic [2:0]       r_class;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_halted;
  logic             r_error;

  logic [2:0] w_state_next;
  logic [7:0] w_wait_next;
  logic       w_set_error;
  logic [2:0] w_class_dec;
  logic [2:0] w_class_eff;
  logic       w_static_en;

  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_pc_src;
  logic       w_reg_to_loc;
  logic       w_reg_write;
  logic       w_alu_src;
  logic [1:0] w_alu_op;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_mem_to_reg;

  always_comb begin
    w_class_dec  = decode_class(bus.opcode);
    // The class register is only loaded at the end of DECODE, so DECODE
    // itself drives the class-static selects from the live decode.
    w_class_eff  = (r_state == S_DECODE) ? w_class_dec : r_class;
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_set_error  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_state_next = (w_class_dec == C_NONE) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (r_class)
          C_R:  w_state_next = S_WB;
          C_LD,
          C_ST: begin
            w_state_next = S_MEM;
            w_wait_next  = 8'd0;
          end
          C_CBZ: begin
            w_pc_write   = 1'b1;
            w_pc_src     = bus.zero;
            w_state_next = S_FETCH;
          end
          C_B: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 1'b1;
            w_state_next = S_FETCH;
          end
          default: w_state_next = S_HALT;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_class == C_ST);
        // Ready wins even on the last allowed cycle.
        if (bus.mem_ready) begin
          if (r_class == C_ST) begin
            w_pc_write   = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_state_next = S_HALT;
          w_set_error  = 1'b1;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_HALT;
    endcase

    w_static_en  = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                   (r_state == S_MEM)    || (r_state == S_WB);
    w_reg_to_loc = w_static_en && ((w_class_eff == C_ST) || (w_class_eff == C_CBZ));
    w_alu_src    = w_static_en && ((w_class_eff == C_LD) || (w_class_eff == C_ST));
    w_mem_to_reg = w_static_en && (w_class_eff == C_LD);
    w_alu_op     = 2'b00;
    if (w_static_en) begin
      if (w_class_eff == C_R)
        w_alu_op = 2'b10;
      else if ((w_class_eff == C_CBZ) || (w_class_eff == C_B))
        w_alu_op = 2'b01;
    end

    // Reset silences everything in the same cycle, including a pending mem_req.
    if (reset) begin
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 1'b0;
      w_reg_to_loc = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_op     = 2'b00;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_class       <= C_NONE;
      r_wait        <= 8'd0;
      r_instr_count <= '0;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (r_state == S_DECODE)
        r_class <= w_class_dec;
      if (w_pc_write)
        r_instr_count <= r_instr_count + 1'b1;
      if (w_state_next == S_HALT)
        r_halted <= 1'b1;
      if (w_set_error)
        r_error <= 1'b1;
    end
  end

  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.pc_src      = w_pc_src;
  assign bus.reg_to_loc  = w_reg_to_loc;
  assign bus.reg_write   = w_reg_write;
  assign bus.alu_src     = w_alu_src;
  assign bus.alu_op      = w_alu_op;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.halted      = reset ? 1'b0 : r_halted;
  assign bus.error       = reset ? 1'b0 : r_error;
  assign bus.instr_count = reset ? '0 : r_instr_count;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed, cycle-by-cycle stimulus for multicycle_controller (TIMEOUT=4).
// Output vector layout used by the expected values below:
//   [12] ir_write [11] pc_write [10] pc_src [9] reg_to_loc [8] reg_write
//   [7] alu_src [6:5] alu_op [4] mem_req [3] mem_we [2] mem_to_reg
//   [1] halted [0] error
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111011;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  multicycle_controller_if #(.CNT_W(32)) bus ();

  multicycle_controller #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] out_vec();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_to_loc,
            bus.reg_write, bus.alu_src, bus.alu_op, bus.mem_req,
            bus.mem_we, bus.mem_to_reg, bus.halted, bus.error};
  endfunction

  // One clock: after the edge, apply inputs, let them settle, check outputs.
  task automatic cyc(input string tag, input logic rst, input logic [10:0] op,
                     input logic z, input logic rdy, input logic [12:0] exp_v);
    logic [12:0] obs;
    @(posedge clk);
    #2;
    reset         = rst;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
    obs = out_vec();
    n_checks++;
    $display("cyc %-12s rst=%0b op=%b z=%0b rdy=%0b out=%h exp=%h cnt=%0d",
             tag, rst, op, z, rdy, obs, exp_v, bus.instr_count);
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s outputs obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp_c);
    n_checks++;
    assert (bus.instr_count === exp_c) else begin
      n_errors++;
      $error("FAIL %s instr_count obs=%0d exp=%0d", tag, bus.instr_count, exp_c);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset: everything low
    cyc("reset",     1, OP_ADD, 0, 0, 13'h0000);
    chk_cnt("reset_cnt", 0);

    // ADD: 4 cycles
    cyc("add_fetch", 0, OP_ADD, 0, 0, 13'h1000);
    cyc("add_dec",   0, OP_ADD, 0, 0, 13'h0040);
    cyc("add_exec",  0, OP_ADD, 0, 0, 13'h0040);
    chk_cnt("add_cnt0", 0);
    cyc("add_wb",    0, OP_ADD, 0, 0, 13'h0940);

    // LDUR with 3 wait cycles: 8 cycles
    cyc("ld_fetch",  0, OP_LDUR, 0, 1, 13'h1000);
    chk_cnt("add_cnt1", 1);
    cyc("ld_dec",    0, OP_LDUR, 0, 1, 13'h0084);
    cyc("ld_exec",   0, OP_LDUR, 0, 1, 13'h0084);
    cyc("ld_mem1",   0, OP_LDUR, 0, 0, 13'h0094);
    cyc("ld_mem2",   0, OP_LDUR, 0, 0, 13'h0094);
    cyc("ld_mem3",   0, OP_LDUR, 0, 0, 13'h0094);
    cyc("ld_mem4",   0, OP_LDUR, 0, 1, 13'h0094);
    cyc("ld_wb",     0, OP_LDUR, 0, 0, 13'h0984);

    // CBZ taken, then not taken
    cyc("cbz1_f",    0, OP_CBZ, 1, 0, 13'h1000);
    chk_cnt("ld_cnt", 2);
    cyc("cbz1_d",    0, OP_CBZ, 1, 0, 13'h0220);
    cyc("cbz1_e",    0, OP_CBZ, 1, 0, 13'h0E20);
    cyc("cbz0_f",    0, OP_CBZ, 0, 0, 13'h1000);
    chk_cnt("cbz1_cnt", 3);
    cyc("cbz0_d",    0, OP_CBZ, 0, 0, 13'h0220);
    cyc("cbz0_e",    0, OP_CBZ, 0, 0, 13'h0A20);

    // B: always taken
    cyc("b_f",       0, OP_B, 0, 0, 13'h1000);
    chk_cnt("cbz0_cnt", 4);
    cyc("b_d",       0, OP_B, 0, 0, 13'h0020);
    cyc("b_e",       0, OP_B, 0, 0, 13'h0C20);

    // STUR, ready on exactly the 4th (last allowed) MEM cycle; ready in EXEC ignored
    cyc("st_f",      0, OP_STUR, 0, 1, 13'h1000);
    chk_cnt("b_cnt", 5);
    cyc("st_d",      0, OP_STUR, 0, 1, 13'h0280);
    cyc("st_e",      0, OP_STUR, 0, 1, 13'h0280);
    cyc("st_mem1",   0, OP_STUR, 0, 0, 13'h0298);
    cyc("st_mem2",   0, OP_STUR, 0, 0, 13'h0298);
    cyc("st_mem3",   0, OP_STUR, 0, 0, 13'h0298);
    cyc("st_mem4",   0, OP_STUR, 0, 1, 13'h0A98);

    // ORR: another R-type
    cyc("orr_f",     0, OP_ORR, 0, 0, 13'h1000);
    chk_cnt("st_cnt", 6);
    cyc("orr_d",     0, OP_ORR, 0, 0, 13'h0040);
    cyc("orr_e",     0, OP_ORR, 0, 0, 13'h0040);
    cyc("orr_wb",    0, OP_ORR, 0, 0, 13'h0940);

    // STUR timeout: 4 MEM cycles then HALT with error
    cyc("sto_f",     0, OP_STUR, 0, 0, 13'h1000);
    chk_cnt("orr_cnt", 7);
    cyc("sto_d",     0, OP_STUR, 0, 0, 13'h0280);
    cyc("sto_e",     0, OP_STUR, 0, 0, 13'h0280);
    cyc("sto_mem1",  0, OP_STUR, 0, 0, 13'h0298);
    cyc("sto_mem2",  0, OP_STUR, 0, 0, 13'h0298);
    cyc("sto_mem3",  0, OP_STUR, 0, 0, 13'h0298);
    cyc("sto_mem4",  0, OP_STUR, 0, 0, 13'h0298);
    cyc("sto_halt1", 0, OP_STUR, 1, 1, 13'h0003);
    cyc("sto_halt2", 0, OP_ADD,  1, 1, 13'h0003);
    cyc("sto_halt3", 0, OP_B,    0, 0, 13'h0003);
    chk_cnt("sto_cnt", 7);

    // Reset clears halt; illegal opcode halts with error=0
    cyc("rst2",      1, OP_ILL, 0, 0, 13'h0000);
    cyc("ill_f",     0, OP_ILL, 0, 0, 13'h1000);
    chk_cnt("rst2_cnt", 0);
    cyc("ill_d",     0, OP_ILL, 0, 0, 13'h0000);
    cyc("ill_halt1", 0, OP_ILL, 1, 1, 13'h0002);
    cyc("ill_halt2", 0, OP_ADD, 0, 1, 13'h0002);
    chk_cnt("ill_cnt", 0);

    // Reset, then reset again during the second MEM cycle of an LDUR
    cyc("rst3",      1, OP_LDUR, 0, 0, 13'h0000);
    cyc("ldr_f",     0, OP_LDUR, 0, 0, 13'h1000);
    cyc("ldr_d",     0, OP_LDUR, 0, 0, 13'h0084);
    cyc("ldr_e",     0, OP_LDUR, 0, 0, 13'h0084);
    cyc("ldr_mem1",  0, OP_LDUR, 0, 0, 13'h0094);
    cyc("ldr_rst",   1, OP_LDUR, 0, 1, 13'h0000);
    cyc("ldr_f2",    0, OP_LDUR, 0, 0, 13'h1000);
    chk_cnt("ldr_cnt", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
